// File: rtl/sram_arbiter_pkg.sv
// Shared types for the dual-port SRAM arbiter: FSM state encoding and the
// access-phase wait counter.
package sram_arbiter_pkg;

    localparam int WAIT_CNT_W = 4;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin grant; on a tie the port not granted last wins.
module sram_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    // 1 = port B was granted last, so port A wins the first tie after reset
    logic last_grant_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (update_i && (gnt_o != 2'b00)) begin
            last_grant_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between a CPU port (A) and a DMA port (B) using a
// SETUP / ACCESS / HOLD strobe sequence with registered pad outputs.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  io_mainClk,
    input  logic                  io_asyncReset_n,
    input  logic                  io_a_cmd_valid,
    output logic                  io_a_cmd_ready,
    input  logic                  io_a_cmd_write,
    input  logic [ADDR_WIDTH-1:0] io_a_cmd_addr,
    input  logic [DATA_WIDTH-1:0] io_a_cmd_wdata,
    input  logic [1:0]            io_a_cmd_mask,
    output logic                  io_a_rsp_valid,
    output logic [DATA_WIDTH-1:0] io_a_rsp_rdata,
    input  logic                  io_b_cmd_valid,
    output logic                  io_b_cmd_ready,
    input  logic                  io_b_cmd_write,
    input  logic [ADDR_WIDTH-1:0] io_b_cmd_addr,
    input  logic [DATA_WIDTH-1:0] io_b_cmd_wdata,
    input  logic [1:0]            io_b_cmd_mask,
    output logic                  io_b_rsp_valid,
    output logic [DATA_WIDTH-1:0] io_b_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] io_sram_addr,
    input  logic [DATA_WIDTH-1:0] io_sram_dat_read,
    output logic [DATA_WIDTH-1:0] io_sram_dat_write,
    output logic                  io_sram_dat_writeEnable,
    output logic                  io_sram_cs,
    output logic                  io_sram_we,
    output logic                  io_sram_oe,
    output logic                  io_sram_ub,
    output logic                  io_sram_lb
);

    localparam wait_cnt_t WAIT_LAST = wait_cnt_t'(WAIT_CYCLES - 1);

    state_e                state_q;
    wait_cnt_t             cnt_q;
    logic                  port_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dat_write_q;
    logic                  dat_we_q;
    logic                  cs_q, we_q, oe_q, ub_q, lb_q;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q [2];

    logic                  cmd_write [2];
    logic [ADDR_WIDTH-1:0] cmd_addr  [2];
    logic [DATA_WIDTH-1:0] cmd_wdata [2];
    logic [1:0]            cmd_mask  [2];
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  accept;
    logic                  sel;

    assign req       = {io_b_cmd_valid, io_a_cmd_valid};
    assign cmd_write = '{io_a_cmd_write, io_b_cmd_write};
    assign cmd_addr  = '{io_a_cmd_addr,  io_b_cmd_addr};
    assign cmd_wdata = '{io_a_cmd_wdata, io_b_cmd_wdata};
    assign cmd_mask  = '{io_a_cmd_mask,  io_b_cmd_mask};

    assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);
    assign sel    = gnt[1];

    sram_rr_arbiter u_rr (
        .clk      (io_mainClk),
        .rst_n    (io_asyncReset_n),
        .req_i    (req),
        .update_i (accept),
        .gnt_o    (gnt)
    );

    // Grant already implies the request is valid, so ready needs only the state gate
    assign io_a_cmd_ready = (state_q == ST_IDLE) && gnt[PORT_A];
    assign io_b_cmd_ready = (state_q == ST_IDLE) && gnt[PORT_B];
    assign io_a_rsp_valid = rsp_valid_q[PORT_A];
    assign io_b_rsp_valid = rsp_valid_q[PORT_B];
    assign io_a_rsp_rdata = rdata_q[PORT_A];
    assign io_b_rsp_rdata = rdata_q[PORT_B];

    assign io_sram_addr            = addr_q;
    assign io_sram_dat_write       = dat_write_q;
    assign io_sram_dat_writeEnable = dat_we_q;
    assign io_sram_cs              = cs_q;
    assign io_sram_we              = we_q;
    assign io_sram_oe              = oe_q;
    assign io_sram_ub              = ub_q;
    assign io_sram_lb              = lb_q;

    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            dat_write_q <= '0;
            dat_we_q    <= 1'b0;
            cs_q        <= 1'b1;
            we_q        <= 1'b1;
            oe_q        <= 1'b1;
            ub_q        <= 1'b1;
            lb_q        <= 1'b1;
            rsp_valid_q <= 2'b00;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Strobes are registered, so SETUP values are loaded on the accept edge
                    if (accept) begin
                        state_q <= ST_SETUP;
                        port_q  <= sel;
                        write_q <= cmd_write[sel];
                        addr_q  <= cmd_addr[sel];
                        cs_q    <= 1'b0;
                        if (cmd_write[sel]) begin
                            dat_we_q    <= 1'b1;
                            dat_write_q <= cmd_wdata[sel];
                            ub_q        <= ~cmd_mask[sel][1];
                            lb_q        <= ~cmd_mask[sel][0];
                        end else begin
                            oe_q <= 1'b0;
                            ub_q <= 1'b0;
                            lb_q <= 1'b0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    cnt_q   <= WAIT_LAST;
                    if (write_q) begin
                        we_q <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q             <= ST_HOLD;
                        we_q                <= 1'b1;
                        rsp_valid_q[port_q] <= 1'b1;
                        if (!write_q) begin
                            rdata_q[port_q] <= io_sram_dat_read;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 2'b00;
                    cs_q        <= 1'b1;
                    oe_q        <= 1'b1;
                    ub_q        <= 1'b1;
                    lb_q        <= 1'b1;
                    dat_we_q    <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: cycle-level phase model plus directed scenarios on a
// WAIT_CYCLES=1 instance and a WAIT_CYCLES=15 instance.
module tb_sram_arbiter;

    localparam int W0 = 1;
    localparam int W1 = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // WAIT_CYCLES=1 instance
    logic        a_valid = 0, a_ready, a_write = 0, a_rsp;
    logic [17:0] a_addr = '0;
    logic [15:0] a_wdata = '0, a_rdata;
    logic [1:0]  a_mask = '0;
    logic        b_valid = 0, b_ready, b_write = 0, b_rsp;
    logic [17:0] b_addr = '0;
    logic [15:0] b_wdata = '0, b_rdata;
    logic [1:0]  b_mask = '0;
    logic [17:0] s_addr;
    logic [15:0] s_rd, s_wd;
    logic        s_dwe, s_cs, s_we, s_oe, s_ub, s_lb;

    sram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .WAIT_CYCLES(W0)) dut0 (
        .io_mainClk(clk), .io_asyncReset_n(rst_n),
        .io_a_cmd_valid(a_valid), .io_a_cmd_ready(a_ready), .io_a_cmd_write(a_write),
        .io_a_cmd_addr(a_addr), .io_a_cmd_wdata(a_wdata), .io_a_cmd_mask(a_mask),
        .io_a_rsp_valid(a_rsp), .io_a_rsp_rdata(a_rdata),
        .io_b_cmd_valid(b_valid), .io_b_cmd_ready(b_ready), .io_b_cmd_write(b_write),
        .io_b_cmd_addr(b_addr), .io_b_cmd_wdata(b_wdata), .io_b_cmd_mask(b_mask),
        .io_b_rsp_valid(b_rsp), .io_b_rsp_rdata(b_rdata),
        .io_sram_addr(s_addr), .io_sram_dat_read(s_rd), .io_sram_dat_write(s_wd),
        .io_sram_dat_writeEnable(s_dwe), .io_sram_cs(s_cs), .io_sram_we(s_we),
        .io_sram_oe(s_oe), .io_sram_ub(s_ub), .io_sram_lb(s_lb)
    );

    // WAIT_CYCLES=15 instance, port B idle
    logic        x_a_valid = 0, x_a_ready, x_a_rsp;
    logic [17:0] x_a_addr = '0;
    logic [15:0] x_a_rdata;
    logic        x_b_ready, x_b_rsp;
    logic [15:0] x_b_rdata;
    logic [17:0] x_addr;
    logic [15:0] x_rd, x_wd;
    logic        x_dwe, x_cs, x_we, x_oe, x_ub, x_lb;

    sram_arbiter #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .WAIT_CYCLES(W1)) dut1 (
        .io_mainClk(clk), .io_asyncReset_n(rst_n),
        .io_a_cmd_valid(x_a_valid), .io_a_cmd_ready(x_a_ready), .io_a_cmd_write(1'b0),
        .io_a_cmd_addr(x_a_addr), .io_a_cmd_wdata(16'h0000), .io_a_cmd_mask(2'b11),
        .io_a_rsp_valid(x_a_rsp), .io_a_rsp_rdata(x_a_rdata),
        .io_b_cmd_valid(1'b0), .io_b_cmd_ready(x_b_ready), .io_b_cmd_write(1'b0),
        .io_b_cmd_addr(18'h0), .io_b_cmd_wdata(16'h0000), .io_b_cmd_mask(2'b00),
        .io_b_rsp_valid(x_b_rsp), .io_b_rsp_rdata(x_b_rdata),
        .io_sram_addr(x_addr), .io_sram_dat_read(x_rd), .io_sram_dat_write(x_wd),
        .io_sram_dat_writeEnable(x_dwe), .io_sram_cs(x_cs), .io_sram_we(x_we),
        .io_sram_oe(x_oe), .io_sram_ub(x_ub), .io_sram_lb(x_lb)
    );

    assign x_rd = (!x_cs && !x_oe) ? 16'h1234 : 16'h0000;

    function automatic logic [15:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (b == 8'h23) return 16'hBEEF;
        return {b, ~b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Physical SRAM behind dut0, byte-lane writes while cs and we are both low
    logic [15:0] sram_mem [256];
    assign s_rd = (!s_cs && !s_oe) ? sram_mem[s_addr[7:0]] : 16'h0000;

    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (!s_cs && !s_we && s_dwe) begin
                if (!s_ub) sram_mem[s_addr[7:0]][15:8] = s_wd[15:8];
                if (!s_lb) sram_mem[s_addr[7:0]][7:0]  = s_wd[7:0];
            end
        end
    end

    // Reference model: a transaction occupies phases 1..W0+2 after acceptance
    logic [15:0] ref_mem [256];
    logic [15:0] m_rdata [2];
    logic        m_busy, m_port, m_write, m_last;
    int          m_k;
    logic [17:0] m_addr, m_addr_out;
    logic [15:0] m_wdata, m_wd_out;
    logic [1:0]  m_mask;
    int          log_port[$];
    int          log_cyc[$];

    initial begin
        int   cyc;
        int   g;
        logic [5:0] exp_str;
        logic [1:0] exp_rsp, exp_rdy;
        cyc = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_busy = 0; m_k = 0; m_last = 1; m_port = 0; m_write = 0;
                m_addr_out = '0; m_wd_out = '0; m_rdata[0] = '0; m_rdata[1] = '0;
            end
            g = -1;
            if (a_valid && b_valid) g = m_last ? 0 : 1;
            else if (a_valid)       g = 0;
            else if (b_valid)       g = 1;
            exp_rdy = 2'b00;
            if (rst_n && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
            exp_rsp = 2'b00;
            if (m_busy) begin
                exp_str[5] = 1'b0;
                exp_str[4] = (m_write && m_k >= 2 && m_k <= W0 + 1) ? 1'b0 : 1'b1;
                exp_str[3] = m_write;
                exp_str[2] = m_write ? ~m_mask[1] : 1'b0;
                exp_str[1] = m_write ? ~m_mask[0] : 1'b0;
                exp_str[0] = m_write;
                if (m_k == W0 + 2) exp_rsp[m_port] = 1'b1;
            end else begin
                exp_str = 6'b111110;
            end
            chk("strobes", {s_cs, s_we, s_oe, s_ub, s_lb, s_dwe}, exp_str);
            chk("ready", {b_ready, a_ready}, exp_rdy);
            chk("rsp_valid", {b_rsp, a_rsp}, exp_rsp);
            chk("sram_addr", s_addr, m_addr_out);
            chk("dat_write", s_wd, m_wd_out);
            chk("rdata_a", a_rdata, m_rdata[0]);
            chk("rdata_b", b_rdata, m_rdata[1]);
            if (rst_n) begin
                if (a_valid && a_ready) begin log_port.push_back(0); log_cyc.push_back(cyc); end
                if (b_valid && b_ready) begin log_port.push_back(1); log_cyc.push_back(cyc); end
                if (m_busy) begin
                    if (m_k == W0 + 2) m_busy = 0;
                    else begin
                        m_k++;
                        if (m_k == W0 + 2) begin
                            if (!m_write) m_rdata[m_port] = ref_mem[m_addr[7:0]];
                            else begin
                                if (m_mask[1]) ref_mem[m_addr[7:0]][15:8] = m_wdata[15:8];
                                if (m_mask[0]) ref_mem[m_addr[7:0]][7:0]  = m_wdata[7:0];
                            end
                        end
                    end
                end else if (g >= 0) begin
                    m_busy = 1; m_k = 1; m_port = (g == 1); m_last = (g == 1);
                    m_write = g ? b_write : a_write;
                    m_addr  = g ? b_addr  : a_addr;
                    m_wdata = g ? b_wdata : a_wdata;
                    m_mask  = g ? b_mask  : a_mask;
                    m_addr_out = m_addr;
                    if (m_write) m_wd_out = m_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command on dut0 and return #1 into the SETUP cycle
    task automatic issue(input bit port, input bit wr, input logic [17:0] ad,
                         input logic [15:0] wd, input logic [1:0] mk);
        bit ok;
        if (port) begin b_write = wr; b_addr = ad; b_wdata = wd; b_mask = mk; b_valid = 1; end
        else      begin a_write = wr; a_addr = ad; a_wdata = wd; a_mask = mk; a_valid = 1; end
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (port ? b_ready : a_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        a_valid = 0;
        b_valid = 0;
        chk("accept_in_time", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int oe_cnt, rsp_cyc;
        bit ok;
        logic [15:0] rd;

        tick();
        chk("reset_strobes", {s_cs, s_we, s_oe, s_ub, s_lb, s_dwe}, 6'b111110);
        chk("reset_addr", s_addr, 18'h0);
        chk("reset_rdata", {a_rdata, b_rdata}, 32'h0);
        tick();
        rst_n = 1;

        // A-only read
        issue(0, 0, 18'h00123, 16'h0000, 2'b11);
        chk("t1_oe_c1", s_oe, 0);
        tick(); chk("t1_oe_c2", s_oe, 0);
        tick(); chk("t1_oe_c3", s_oe, 0); chk("t1_rsp_c3", a_rsp, 1); chk("t1_rdata", a_rdata, 16'hBEEF);
        tick(); chk("t1_oe_c4", s_oe, 1); chk("t1_rsp_c4", a_rsp, 0);

        // B write, upper byte only
        issue(1, 1, 18'h00045, 16'h5A5A, 2'b10);
        chk("t2_ublb", {s_ub, s_lb}, 2'b01); chk("t2_we_c1", s_we, 1);
        chk("t2_dwe_c1", s_dwe, 1); chk("t2_wd_c1", s_wd, 16'h5A5A);
        tick(); chk("t2_we_c2", s_we, 0); chk("t2_wd_c2", s_wd, 16'h5A5A);
        tick(); chk("t2_we_c3", s_we, 1); chk("t2_rsp", b_rsp, 1); chk("t2_wd_c3", s_wd, 16'h5A5A);
        tick(); chk("t2_mem", sram_mem[8'h45], 16'h5ABA);

        // Both ports continuously valid
        log_port.delete(); log_cyc.delete();
        a_write = 0; a_addr = 18'h00010; a_mask = 2'b11;
        b_write = 1; b_addr = 18'h00020; b_wdata = 16'h1357; b_mask = 2'b11;
        a_valid = 1; b_valid = 1;
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            tick();
            if (log_port.size() >= 6) ok = 1;
        end
        a_valid = 0; b_valid = 0;
        chk("t3_six_accepts", {31'd0, ok}, 32'd1);
        if (ok) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), log_port[i], i % 2);
            for (int i = 1; i < 6; i++) chk($sformatf("t3_gap%0d", i), log_cyc[i] - log_cyc[i-1], 4);
        end
        repeat (4) tick();
        chk("t3_mem", sram_mem[8'h20], 16'h1357);

        // Reset during ACCESS of a write
        issue(0, 1, 18'h00030, 16'h7777, 2'b11);
        tick(); chk("t4_we_access", s_we, 0);
        #1 rst_n = 0;
        #1;
        chk("t4_rst_we", s_we, 1); chk("t4_rst_cs", s_cs, 1); chk("t4_rst_dwe", s_dwe, 0);
        tick(); tick();
        rst_n = 1;
        chk("t4_mem_intact", sram_mem[8'h30], 16'h30CF);
        issue(0, 0, 18'h00030, 16'h0000, 2'b11);
        tick(); tick(); chk("t4_rsp", a_rsp, 1); chk("t4_rdata", a_rdata, 16'h30CF);
        tick();

        // Write with no byte enables
        issue(1, 1, 18'h00050, 16'hFFFF, 2'b00);
        chk("t6_ublb_c1", {s_ub, s_lb}, 2'b11);
        tick(); chk("t6_ublb_c2", {s_ub, s_lb}, 2'b11);
        tick(); chk("t6_rsp", b_rsp, 1); chk("t6_ublb_c3", {s_ub, s_lb}, 2'b11);
        tick(); chk("t6_mem", sram_mem[8'h50], 16'h50AF);

        // WAIT_CYCLES=15 read
        x_a_addr = 18'h00005; x_a_valid = 1;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (x_a_ready) ok = 1;
        end
        @(posedge clk); #1;
        x_a_valid = 0;
        chk("t5_accept", {31'd0, ok}, 32'd1);
        oe_cnt = 0; rsp_cyc = 0; rd = '0;
        for (int c = 1; c <= 25; c++) begin
            if (!x_oe) oe_cnt++;
            if (x_a_rsp) begin rsp_cyc = c; rd = x_a_rdata; end
            tick();
        end
        chk("t5_oe_cycles", oe_cnt, W1 + 2);
        chk("t5_rsp_cycle", rsp_cyc, 17);
        chk("t5_rdata", rd, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SRAM data width; byte lanes are fixed at two.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 1..15, length of the strobe-active access phase.
REQ-004 SHALL have these ports (all other ports on the same clock):
- io_mainClk, in, 1: sole clock.
- io_asyncReset_n, in, 1: reset, asynchronous, active-low.
- io_a_cmd_valid / io_a_cmd_ready, in/out, 1/1: port A (CPU) command handshake.
- io_a_cmd_write, in, 1: 1 = write, 0 = read.
- io_a_cmd_addr, in, ADDR_WIDTH: word address.
- io_a_cmd_wdata, in, DATA_WIDTH: write data.
- io_a_cmd_mask, in, 2: byte enables; bit1 = upper byte, bit0 = lower byte.
- io_a_rsp_valid, out, 1: completion pulse.
- io_a_rsp_rdata, out, DATA_WIDTH: read data.
- io_b_*: port B (DMA), identical set.
- io_sram_addr, out, ADDR_WIDTH.
- io_sram_dat_read, in, DATA_WIDTH.
- io_sram_dat_write, out, DATA_WIDTH.
- io_sram_dat_writeEnable, out, 1: pad output enable.
- io_sram_cs / io_sram_we / io_sram_oe / io_sram_ub / io_sram_lb, out, 1 each: active-low SRAM strobes.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, HOLD.
REQ-006 In IDLE, cmd_ready SHALL be asserted combinationally to the granted port only, and only when that port's cmd_valid is high; ready SHALL be low in all other states.
REQ-007 On acceptance, SHALL register port id, write, addr, wdata and mask, then go to SETUP.
REQ-008 Arbitration SHALL be round-robin: if one port is valid, grant it; if both are valid, grant the port not granted last.
REQ-009 last_grant SHALL reset to B, so A wins the first tie.
REQ-010 SETUP (1 cycle):
- drive addr; cs=0.
- read: oe=0, ub=lb=0.
- write: dat_writeEnable=1, dat_write=wdata, ub/lb = ~mask; we stays 1.
REQ-011 ACCESS SHALL last exactly WAIT_CYCLES cycles, with SETUP strobes held and, for writes, we=0.
REQ-012 On the last ACCESS cycle of a read, SHALL capture io_sram_dat_read into the owning port's rdata register.
REQ-013 HOLD (1 cycle):
- we=1; cs, addr and write data still driven; oe=0 kept for reads.
- owning port's rsp_valid=1 for exactly this cycle, for both reads and writes.
- next state is IDLE.
REQ-014 Timing: rdata SHALL be held until that port's next read completes; accept-to-rsp_valid latency SHALL be WAIT_CYCLES+2 cycles; back-to-back throughput SHALL be one access per WAIT_CYCLES+3 cycles.
REQ-015 In IDLE all strobes SHALL be 1, dat_writeEnable=0, and addr holds its last value.
REQ-016 A write with mask=00 SHALL run the full cycle with ub=lb=1 and still return rsp_valid.
REQ-017 Maximum wait for a continuously valid port SHALL be one foreign access.
REQ-018 A command that is valid but not yet accepted SHALL NOT affect the cycle in progress.

Reset
REQ-019 While io_asyncReset_n=0, immediately, independent of the clock:
- state=IDLE.
- cs=we=oe=ub=lb=1.
- dat_writeEnable=0.
- ready=0, rsp_valid=0.
- addr=0, dat_write=0, rdata=0.
REQ-020 Reset asserted mid-access SHALL abort it with no rsp_valid.
REQ-021 After release, SHALL accept commands from the first rising edge.

Structure
REQ-022 State encoding and the WAIT_CYCLES counter width (4 bits) SHALL be defined in package sram_arbiter_pkg.
REQ-023 Grant logic SHALL be a sub-module sram_rr_arbiter (2 requests, 2 one-hot grants, last_grant register, update enable).

Verification
REQ-024 The bench SHALL cover, with WAIT_CYCLES=1 unless stated:
- A-only read at addr 0x00123, SRAM model returns 0xBEEF -> oe low for cycles 1-3, io_a_rsp_valid at cycle 3, io_a_rsp_rdata=0xBEEF.
- B write 0x5A5A, mask 10 -> ub=0, lb=1, we low for exactly 1 cycle with data stable 1 cycle before and after; SRAM upper byte=0x5A, lower unchanged.
- A and B both valid continuously for 6 accesses -> grants alternate A,B,A,B,A,B; accesses start 4 cycles apart.
- io_asyncReset_n pulled low during ACCESS of a write -> we, cs high the same cycle; no rsp_valid; next command completes normally.
- WAIT_CYCLES=15, A read -> ACCESS spans 15 cycles; rsp_valid at cycle 17.
- Write with mask 00 -> ub=lb=1 throughout; rsp_valid returned; memory unchanged.
